// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch sequencer: command FSM, count-tick prescaler and a cascade of BCD digit counters.
// Optional lap-display feature is compiled in with the BCD_STOPWATCH_LAP_EN macro.
module bcd_stopwatch_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10,
    parameter int PS_W     = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  clear_i,
`ifdef BCD_STOPWATCH_LAP_EN
    input  logic                  lap_i,
    output logic                  lap_active_o,
`endif
    output logic [4*DIGITS-1:0]   digits_o,
    output logic                  running_o,
    output logic                  overflow_o,
    output logic                  tick_o,
    output logic [1:0]            state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVF   = 2'b11
    } state_t;

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0] PS_ZERO = '0;

    state_t                   state_r;
    state_t                   state_nxt_s;
    logic [PS_W-1:0]          ps_r;
    logic [PS_W-1:0]          ps_nxt_s;
    logic [DIGITS-1:0][3:0]   digit_r;
    logic [DIGITS-1:0][3:0]   digit_nxt_s;
    logic [DIGITS-1:0]        en_s;
    logic                     tick_s;
    logic                     term_s;
    logic                     clr_digits_s;

    // A tick is lost on any cycle where a stop or clear request wins.
    always_comb begin
        tick_s = (state_r == ST_RUN) && (ps_r == PS_LAST) && !clear_i && !stop_i;
    end

    // Ripple enables: digit i advances when every lower digit is about to wrap.
    always_comb begin
        en_s    = '0;
        en_s[0] = tick_s;
        for (int i = 1; i < DIGITS; i++) begin
            en_s[i] = en_s[i-1] && (digit_r[i-1] == 4'd9);
        end
        term_s = en_s[DIGITS-1] && (digit_r[DIGITS-1] == 4'd9);
    end

    // Next-state and prescaler decode; request priority is clear > stop > start.
    always_comb begin
        state_nxt_s  = state_r;
        ps_nxt_s     = ps_r;
        clr_digits_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (clear_i) begin
                    clr_digits_s = 1'b1;
                    ps_nxt_s     = PS_ZERO;
                end else if (start_i) begin
                    state_nxt_s = ST_RUN;
                    ps_nxt_s    = PS_ZERO;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                ps_nxt_s = (ps_r >= PS_LAST) ? PS_ZERO : ps_r + PS_W'(1);
                if (clear_i) begin
                    state_nxt_s  = ST_IDLE;
                    clr_digits_s = 1'b1;
                    ps_nxt_s     = PS_ZERO;
                end else if (stop_i) begin
                    state_nxt_s = ST_PAUSE;
                end else if (term_s) begin
                    state_nxt_s = ST_OVF;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_PAUSE: begin
                // Prescaler is kept so the tick phase survives the pause.
                if (clear_i) begin
                    state_nxt_s  = ST_IDLE;
                    clr_digits_s = 1'b1;
                    ps_nxt_s     = PS_ZERO;
                end else if (stop_i) begin
                    state_nxt_s = ST_PAUSE;
                end else if (start_i) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
            end
            ST_OVF: begin
                if (clear_i) begin
                    state_nxt_s  = ST_IDLE;
                    clr_digits_s = 1'b1;
                    ps_nxt_s     = PS_ZERO;
                end else begin
                    state_nxt_s = ST_OVF;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                clr_digits_s = 1'b1;
                ps_nxt_s     = PS_ZERO;
            end
        endcase
    end

    // Digit update: saturate at terminal count rather than wrapping to zero.
    always_comb begin
        digit_nxt_s = digit_r;
        for (int i = 0; i < DIGITS; i++) begin
            if (clr_digits_s) begin
                digit_nxt_s[i] = 4'd0;
            end else if (term_s) begin
                digit_nxt_s[i] = digit_r[i];
            end else if (en_s[i]) begin
                digit_nxt_s[i] = (digit_r[i] >= 4'd9) ? 4'd0 : digit_r[i] + 4'd1;
            end else begin
                digit_nxt_s[i] = digit_r[i];
            end
        end
    end

    // State, prescaler and digit registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            ps_r    <= PS_ZERO;
            digit_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            ps_r    <= ps_nxt_s;
            digit_r <= digit_nxt_s;
        end
    end

    // State decodes and the tick strobe.
    always_comb begin
        state_o    = state_r;
        running_o  = (state_r == ST_RUN);
        overflow_o = (state_r == ST_OVF);
        tick_o     = tick_s;
    end

`ifdef BCD_STOPWATCH_LAP_EN
    logic                   lap_active_r;
    logic                   lap_active_nxt_s;
    logic [4*DIGITS-1:0]    lap_snap_r;
    logic [4*DIGITS-1:0]    lap_snap_nxt_s;

    // Lap toggle only in RUN; clear or the jump to OVF drops lap mode.
    always_comb begin
        lap_active_nxt_s = lap_active_r;
        lap_snap_nxt_s   = lap_snap_r;
        if (clr_digits_s || term_s) begin
            lap_active_nxt_s = 1'b0;
        end else if ((state_r == ST_RUN) && lap_i) begin
            lap_active_nxt_s = !lap_active_r;
            if (!lap_active_r) begin
                lap_snap_nxt_s = digit_r;
            end else begin
                lap_snap_nxt_s = lap_snap_r;
            end
        end else begin
            lap_active_nxt_s = lap_active_r;
        end
    end

    // Lap mode flag and frozen display value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lap_active_r <= 1'b0;
            lap_snap_r   <= '0;
        end else begin
            lap_active_r <= lap_active_nxt_s;
            lap_snap_r   <= lap_snap_nxt_s;
        end
    end

    // Display source select between snapshot and live count.
    always_comb begin
        lap_active_o = lap_active_r;
        if (lap_active_r) begin
            digits_o = lap_snap_r;
        end else begin
            digits_o = digit_r;
        end
    end
`else
    // Display is always the live count.
    always_comb begin
        digits_o = digit_r;
    end
`endif

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Directed bench for bcd_stopwatch_ctrl: a PRESCALE=10 instance for timing/cascade checks and
// a PRESCALE=2 instance so the terminal-count path is reachable in a short run.
module tb_bcd_stopwatch_ctrl;

    localparam int PRESCALE = 10;

    logic        clk;
    logic        rstn;
    logic        start_i, stop_i, clear_i;
    logic [15:0] digits_o;
    logic        running_o, overflow_o, tick_o;
    logic [1:0]  state_o;

    logic        f_start, f_stop, f_clear;
    logic [15:0] f_digits;
    logic        f_running, f_overflow, f_tick;
    logic [1:0]  f_state;

`ifdef BCD_STOPWATCH_LAP_EN
    logic        lap_i, lap_active_o, f_lap, f_lap_active;
`endif

    int checks = 0;
    int errors = 0;

    bcd_stopwatch_ctrl #(.DIGITS(4), .PRESCALE(10), .PS_W(4)) u_dut (
        .clk(clk), .rstn(rstn),
        .start_i(start_i), .stop_i(stop_i), .clear_i(clear_i),
`ifdef BCD_STOPWATCH_LAP_EN
        .lap_i(lap_i), .lap_active_o(lap_active_o),
`endif
        .digits_o(digits_o), .running_o(running_o), .overflow_o(overflow_o),
        .tick_o(tick_o), .state_o(state_o)
    );

    bcd_stopwatch_ctrl #(.DIGITS(4), .PRESCALE(2), .PS_W(1)) u_fast (
        .clk(clk), .rstn(rstn),
        .start_i(f_start), .stop_i(f_stop), .clear_i(f_clear),
`ifdef BCD_STOPWATCH_LAP_EN
        .lap_i(f_lap), .lap_active_o(f_lap_active),
`endif
        .digits_o(f_digits), .running_o(f_running), .overflow_o(f_overflow),
        .tick_o(f_tick), .state_o(f_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        int cnt;
        int guard;
        cnt = 0;
        guard = 0;
        while (cnt < n && guard < n * PRESCALE + 20) begin
            if (tick_o) cnt++;
            step();
            guard++;
        end
        if (cnt < n) begin
            checks++; errors++;
            $display("FAIL wait_ticks timeout: got %0d ticks want %0d", cnt, n);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic test_reset();
        checks++;
        if (digits_o !== 16'h0000 || state_o !== 2'b00 || running_o !== 1'b0 ||
            overflow_o !== 1'b0 || tick_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: digits=%h state=%b run=%b ovf=%b tick=%b want 0000/00/0/0/0",
                     digits_o, state_o, running_o, overflow_o, tick_o);
        end
        start_i = 1'b1; step(); start_i = 1'b0;
        wait_ticks(42);
        checks++;
        if (digits_o !== 16'h0042) begin
            errors++;
            $display("FAIL preload_42: got %h want 0042", digits_o);
        end
        step(); step(); step();
        rstn = 1'b0;
        #1;
        checks++;
        if (digits_o !== 16'h0000 || state_o !== 2'b00 || running_o !== 1'b0 ||
            overflow_o !== 1'b0 || tick_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: digits=%h state=%b run=%b ovf=%b tick=%b want 0000/00/0/0/0",
                     digits_o, state_o, running_o, overflow_o, tick_o);
        end
`ifdef BCD_STOPWATCH_LAP_EN
        checks++;
        if (lap_active_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_lap: got %b want 0", lap_active_o);
        end
`endif
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic test_start_latency();
        start_i = 1'b1; step(); start_i = 1'b0;
        checks++;
        if (running_o !== 1'b1 || state_o !== 2'b01) begin
            errors++;
            $display("FAIL start_running: run=%b state=%b want 1/01", running_o, state_o);
        end
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (tick_o !== 1'b0) begin
            errors++;
            $display("FAIL tick_early: got %b want 0 at N+8", tick_o);
        end
        step();
        checks++;
        if (tick_o !== 1'b1 || digits_o !== 16'h0000) begin
            errors++;
            $display("FAIL tick_first: tick=%b digits=%h want 1/0000", tick_o, digits_o);
        end
        step();
        checks++;
        if (digits_o !== 16'h0001 || tick_o !== 1'b0) begin
            errors++;
            $display("FAIL first_count: digits=%h tick=%b want 0001/0", digits_o, tick_o);
        end
    endtask

    task automatic test_cascade();
        wait_ticks(8);
        checks++;
        if (digits_o !== 16'h0009) begin
            errors++;
            $display("FAIL count_9: got %h want 0009", digits_o);
        end
        wait_ticks(1);
        checks++;
        if (digits_o !== 16'h0010) begin
            errors++;
            $display("FAIL carry_10: got %h want 0010", digits_o);
        end
        wait_ticks(989);
        checks++;
        if (digits_o !== 16'h0999) begin
            errors++;
            $display("FAIL count_999: got %h want 0999", digits_o);
        end
        wait_ticks(1);
        checks++;
        if (digits_o !== 16'h1000) begin
            errors++;
            $display("FAIL carry_1000: got %h want 1000", digits_o);
        end
    endtask

    task automatic test_pause_resume();
        logic frozen_ok;
        step(); step();
        stop_i = 1'b1; step(); stop_i = 1'b0;
        checks++;
        if (state_o !== 2'b10 || running_o !== 1'b0) begin
            errors++;
            $display("FAIL pause_state: state=%b run=%b want 10/0", state_o, running_o);
        end
        frozen_ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (digits_o !== 16'h1000 || tick_o !== 1'b0) frozen_ok = 1'b0;
        end
        checks++;
        if (frozen_ok !== 1'b1 || digits_o !== 16'h1000) begin
            errors++;
            $display("FAIL pause_frozen: digits=%h want 1000 held with no tick", digits_o);
        end
        start_i = 1'b1; step(); start_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (tick_o !== 1'b0 || running_o !== 1'b1) begin
            errors++;
            $display("FAIL resume_early: tick=%b run=%b want 0/1 at R+5", tick_o, running_o);
        end
        step();
        checks++;
        if (tick_o !== 1'b1) begin
            errors++;
            $display("FAIL resume_tick: got %b want 1 at R+6", tick_o);
        end
        step();
        checks++;
        if (digits_o !== 16'h1001) begin
            errors++;
            $display("FAIL resume_count: got %h want 1001", digits_o);
        end
    endtask

    task automatic test_clear_priority();
        int guard;
        guard = 0;
        while (tick_o !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        clear_i = 1'b1; stop_i = 1'b1; start_i = 1'b1;
        #1;
        checks++;
        if (tick_o !== 1'b0) begin
            errors++;
            $display("FAIL tick_suppress: got %b want 0", tick_o);
        end
        step();
        checks++;
        if (state_o !== 2'b00 || digits_o !== 16'h0000 || running_o !== 1'b0) begin
            errors++;
            $display("FAIL clear_priority: state=%b digits=%h run=%b want 00/0000/0",
                     state_o, digits_o, running_o);
        end
        stop_i = 1'b0; start_i = 1'b0;
        step();
        clear_i = 1'b0;
        checks++;
        if (state_o !== 2'b00 || digits_o !== 16'h0000) begin
            errors++;
            $display("FAIL idle_clear: state=%b digits=%h want 00/0000", state_o, digits_o);
        end
    endtask

    task automatic test_overflow();
        int guard;
        f_start = 1'b1; step(); f_start = 1'b0;
        guard = 0;
        while (f_digits !== 16'h9999 && guard < 25000) begin
            step();
            guard++;
        end
        checks++;
        if (f_digits !== 16'h9999 || f_state !== 2'b01) begin
            errors++;
            $display("FAIL reach_9999: digits=%h state=%b want 9999/01", f_digits, f_state);
        end
        guard = 0;
        while (f_tick !== 1'b1 && guard < 5) begin
            step();
            guard++;
        end
        step();
        checks++;
        if (f_overflow !== 1'b1 || f_digits !== 16'h9999 || f_state !== 2'b11 || f_running !== 1'b0) begin
            errors++;
            $display("FAIL overflow: ovf=%b digits=%h state=%b run=%b want 1/9999/11/0",
                     f_overflow, f_digits, f_state, f_running);
        end
        f_start = 1'b1; step(); f_start = 1'b0;
        f_stop = 1'b1; step(); f_stop = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (f_state !== 2'b11 || f_digits !== 16'h9999 || f_tick !== 1'b0) begin
            errors++;
            $display("FAIL ovf_ignore: state=%b digits=%h tick=%b want 11/9999/0",
                     f_state, f_digits, f_tick);
        end
        f_clear = 1'b1; step(); f_clear = 1'b0;
        checks++;
        if (f_state !== 2'b00 || f_digits !== 16'h0000 || f_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: state=%b digits=%h ovf=%b want 00/0000/0",
                     f_state, f_digits, f_overflow);
        end
    endtask

`ifdef BCD_STOPWATCH_LAP_EN
    task automatic test_lap();
        start_i = 1'b1; step(); start_i = 1'b0;
        wait_ticks(5);
        step(); step();
        lap_i = 1'b1; step(); lap_i = 1'b0;
        checks++;
        if (lap_active_o !== 1'b1 || digits_o !== 16'h0005) begin
            errors++;
            $display("FAIL lap_enter: lap=%b digits=%h want 1/0005", lap_active_o, digits_o);
        end
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (digits_o !== 16'h0005) begin
            errors++;
            $display("FAIL lap_hold: got %h want 0005", digits_o);
        end
        lap_i = 1'b1; step(); lap_i = 1'b0;
        checks++;
        if (lap_active_o !== 1'b0 || digits_o !== 16'h0007) begin
            errors++;
            $display("FAIL lap_leave: lap=%b digits=%h want 0/0007", lap_active_o, digits_o);
        end
        clear_i = 1'b1; step(); clear_i = 1'b0;
    endtask
`endif

    initial begin
        rstn = 1'b0;
        start_i = 1'b0; stop_i = 1'b0; clear_i = 1'b0;
        f_start = 1'b0; f_stop = 1'b0; f_clear = 1'b0;
`ifdef BCD_STOPWATCH_LAP_EN
        lap_i = 1'b0; f_lap = 1'b0;
`endif
        do_reset();
        test_reset();
        test_start_latency();
        test_cascade();
        test_pause_resume();
        test_clear_priority();
        test_overflow();
`ifdef BCD_STOPWATCH_LAP_EN
        test_lap();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
